mesi_bus_arbiter: RTL and testbench
===================================

# mesi_bus_arbiter

Serialises coherence traffic from N private caches onto the single shared snoop bus that feeds every cache's MESI snoop listener. Round-robin arbitration picks one requester, broadcasts its miss or invalidate as a one-hot snoop event, and collects abort/write-back responses from a Modified holder. It then sequences the memory write-back and the fill, and pulses completion to the winner. Sits between the per-cache controllers and the snoop listeners/memory port.

## Interface
- N, 4: number of caches/requesters (2..8)
- WB_CYCLES, 4: cycles mem_wb stays high for one write-back (≥1)

- CLK  in  1  clock, rising edge
- CLR  in  1  reset, synchronous, active-high
- req  in  N  request per cache; held until matching done pulse
- req_cmd  in  2*N  per cache i, bits [2i+1:2i]: 01 read miss, 10 write miss, 11 invalidate, 00 no-op
- snoop_abort  in  N  snooper i holds line Modified: abort memory access / write back; sampled in RESP only
- gnt  out  N  one-hot grant, high from BCAST through DONE
- snoop_event  out  5  one-hot listener event {inv,wh,wm,rh,rm}: rm=00001, wm=00100, inv=10000; zero outside BCAST
- snoop_src  out  $clog2(N)  index of current winner, valid while gnt≠0
- mem_wb  out  1  write-back of aborting cache's block in progress
- mem_rd  out  1  one-cycle memory fill strobe
- done  out  N  one-cycle completion pulse to winner

## Operation
- FSM states: IDLE, BCAST, RESP, WB, FILL, DONE.
- IDLE: eligible = req[i] && req_cmd[i]≠00. If any eligible, latch winner and cmd; go BCAST. Otherwise stay.
- Arbitration: round-robin. Search starts at ptr+1 mod N. After reset ptr=N-1, so cache 0 has top priority.
- BCAST: snoop_event = encoded cmd; snoop_src = winner. Lasts one cycle, then RESP.
- RESP: abort_hit = |(snoop_abort & ~(1<<winner)); the winner's own bit is ignored.
  - cmd=inv → DONE (no memory activity).
  - abort_hit → WB.
  - otherwise → FILL.
- WB: mem_wb=1 for exactly WB_CYCLES cycles (internal down-counter), then FILL.
- FILL: mem_rd=1 for one cycle, then DONE.
- DONE: done[winner]=1 for one cycle; ptr←winner; gnt cleared next cycle; then IDLE.
- req/req_cmd changes after the IDLE latch are ignored; a dropped req does not cancel the transaction.
- snoop_abort outside RESP is ignored.
- Only one transaction is ever outstanding.

## Timing
- Reset (CLR high at edge): state=IDLE, ptr=N-1, counter=0. All outputs 0: gnt, done, snoop_event, snoop_src, mem_wb, mem_rd.
- Reset mid-transaction abandons it; outputs are 0 the cycle after the reset edge, with no done pulse.
- Request sampled in IDLE at edge T:
  - BCAST during T+1, RESP T+2.
  - inv: done during T+3.
  - miss without abort: FILL T+3, done T+4.
  - miss with abort: WB T+3..T+2+WB_CYCLES, FILL T+3+WB_CYCLES, done T+4+WB_CYCLES.
- Minimum IDLE dwell is one cycle between transactions. Next arbitration is at the edge ending the IDLE cycle after DONE.
- All outputs are registered (driven from state/latched registers), with no combinational path from inputs.

## Configuration
- MESI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index eligible always wins; ptr is not updated.
- Undefined (default): round-robin as above.
- Latency and all other behaviour are identical in both builds.

## Test plan
- Reset: drive garbage on inputs with CLR=1 for 2 cycles → all outputs 0; after release, req=0001 with cmd rm → gnt=0001 at T+1, snoop_event=00001 at T+1, mem_rd at T+3, done=0001 at T+4.
- Abort: cache 2 write miss, snoop_abort=0010 in RESP, WB_CYCLES=4 → snoop_event=00100, mem_wb high 4 cycles (T+3..T+6), mem_rd at T+7, done=0100 at T+8.
- Invalidate: cache 1 cmd 11, with snoop_abort=1111 in RESP → no mem_wb, no mem_rd, done=0010 at T+3.
- Fairness: req=1111 held continuously, all rm → grant order 0,1,2,3,0. With MESI_ARB_FIXED_PRIO_EN defined → 0,0,0.
- Self-abort and no-op: winner's own snoop_abort bit set → no WB. req with cmd 00 is never granted.
- Reset mid-WB: CLR asserted during WB → next cycle mem_wb=0, gnt=0, no done. Next request is served normally from cache 0 priority.

Source files
------------

// File: rtl/mesi_bus_arbiter.sv
// Shared snoop-bus arbiter for N MESI caches: grants one requester, broadcasts its snoop event, then sequences write-back, fill and done.
// Define MESI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mesi_bus_arbiter #(
   parameter int N         = 4,
   parameter int WB_CYCLES = 4
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic [N-1:0]         req,
   input  logic [2*N-1:0]       req_cmd,
   input  logic [N-1:0]         snoop_abort,
   output logic [N-1:0]         gnt,
   output logic [4:0]           snoop_event,
   output logic [$clog2(N)-1:0] snoop_src,
   output logic                 mem_wb,
   output logic                 mem_rd,
   output logic [N-1:0]         done
);

   localparam int SW = $clog2(N);
   localparam int CW = $clog2(WB_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      BCAST,
      RESP,
      WB,
      FILL,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   win_q, win_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
`ifndef MESI_ARB_FIXED_PRIO_EN
   logic [SW-1:0]   ptr_q, ptr_d;
`endif

   logic [N-1:0]    elig;
   logic            any_elig;
   logic [SW-1:0]   pick;
   logic [1:0]      pick_cmd;
   logic [N-1:0]    win_onehot;
   logic            abort_hit;
   int              idx;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
         elig[i] = req[i] && (req_cmd[2*i +: 2] != 2'b00);
      end
   end

   // First eligible cache, searching upward from the slot after the last winner.
   always_comb begin
      any_elig = 1'b0;
      pick     = '0;
      pick_cmd = 2'b00;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
`ifdef MESI_ARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = (int'(ptr_q) + 1 + k) % N;
`endif
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            pick     = idx[SW-1:0];
            pick_cmd = req_cmd[2*idx +: 2];
         end
      end
   end

   assign win_onehot = N'(1) << win_q;
   assign abort_hit  = |(snoop_abort & ~win_onehot);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
`ifndef MESI_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               win_d   = pick;
               cmd_d   = pick_cmd;
               state_d = BCAST;
            end
         end
         BCAST: state_d = RESP;
         RESP: begin
            if (cmd_q == 2'b11) begin
               state_d = DONE;
            end else if (abort_hit) begin
               cnt_d   = CW'(WB_CYCLES - 1);
               state_d = WB;
            end else begin
               state_d = FILL;
            end
         end
         WB: begin
            if (cnt_q == '0) begin
               state_d = FILL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FILL: state_d = DONE;
         DONE: begin
`ifndef MESI_ARB_FIXED_PRIO_EN
            ptr_d   = win_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= IDLE;
         win_q   <= '0;
         cmd_q   <= 2'b00;
         cnt_q   <= '0;
`ifndef MESI_ARB_FIXED_PRIO_EN
         ptr_q   <= SW'(N - 1);
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
`ifndef MESI_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Outputs decode only from registered state, never from inputs.
   always_comb begin
      gnt         = '0;
      snoop_event = 5'b00000;
      snoop_src   = '0;
      mem_wb      = 1'b0;
      mem_rd      = 1'b0;
      done        = '0;
      if (state_q != IDLE) begin
         gnt       = win_onehot;
         snoop_src = win_q;
      end
      case (state_q)
         BCAST: begin
            case (cmd_q)
               2'b01:   snoop_event = 5'b00001;
               2'b10:   snoop_event = 5'b00100;
               2'b11:   snoop_event = 5'b10000;
               default: snoop_event = 5'b00000;
            endcase
         end
         WB:      mem_wb = 1'b1;
         FILL:    mem_rd = 1'b1;
         DONE:    done   = win_onehot;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter: per-transaction vector table plus hand-written reset, fairness and reset-mid-WB sequences.
module tb_mesi_bus_arbiter;

   localparam int N         = 4;
   localparam int WB_CYCLES = 4;

   logic         CLK;
   logic         CLR;
   logic [3:0]   req;
   logic [7:0]   req_cmd;
   logic [3:0]   snoop_abort;
   logic [3:0]   gnt;
   logic [4:0]   snoop_event;
   logic [1:0]   snoop_src;
   logic         mem_wb;
   logic         mem_rd;
   logic [3:0]   done;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [3:0] req;
      logic [7:0] cmd;
      logic [3:0] abort;
      int         win_rr;
      int         win_fp;
      logic [4:0] evt;
      bit         wb;
      bit         fill;
   } vec_t;

   vec_t vecs [9];

   mesi_bus_arbiter #(.N(N), .WB_CYCLES(WB_CYCLES)) dut (
      .CLK         (CLK),
      .CLR         (CLR),
      .req         (req),
      .req_cmd     (req_cmd),
      .snoop_abort (snoop_abort),
      .gnt         (gnt),
      .snoop_event (snoop_event),
      .snoop_src   (snoop_src),
      .mem_wb      (mem_wb),
      .mem_rd      (mem_rd),
      .done        (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic compare(input string name, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got {gnt,evt,src,wb,rd,done}=%b, want %b", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input logic [4:0] ev,
                              input logic [1:0] es, input logic ewb, input logic erd,
                              input logic [3:0] ed);
      compare(name, {gnt, snoop_event, snoop_src, mem_wb, mem_rd, done},
              {eg, ev, es, ewb, erd, ed});
   endtask

   task automatic checkIdle(input string name);
      checkOutput(name, 4'b0000, 5'b00000, 2'd0, 1'b0, 1'b0, 4'b0000);
   endtask

   // One whole transaction, checked cycle by cycle from BCAST through the following IDLE.
   task automatic applyStimulus(input int n, input vec_t v);
      int         w;
      logic [3:0] g;
      logic [1:0] s;
`ifdef MESI_ARB_FIXED_PRIO_EN
      w = v.win_fp;
`else
      w = v.win_rr;
`endif
      g = 4'b0001 << w;
      s = w[1:0];
      @(negedge CLK);
      req         = v.req;
      req_cmd     = v.cmd;
      snoop_abort = v.abort;
      @(posedge CLK); #1;
      checkOutput($sformatf("v%0d bcast", n), g, v.evt, s, 1'b0, 1'b0, 4'b0000);
      @(posedge CLK); #1;
      checkOutput($sformatf("v%0d resp", n), g, 5'b00000, s, 1'b0, 1'b0, 4'b0000);
      if (v.wb) begin
         for (int c = 0; c < WB_CYCLES; c++) begin
            @(posedge CLK); #1;
            checkOutput($sformatf("v%0d wb%0d", n, c), g, 5'b00000, s, 1'b1, 1'b0, 4'b0000);
         end
      end
      if (v.fill) begin
         @(posedge CLK); #1;
         checkOutput($sformatf("v%0d fill", n), g, 5'b00000, s, 1'b0, 1'b1, 4'b0000);
      end
      @(posedge CLK); #1;
      checkOutput($sformatf("v%0d done", n), g, 5'b00000, s, 1'b0, 1'b0, g);
      req         = 4'b0000;
      req_cmd     = 8'h00;
      snoop_abort = 4'b0000;
      @(posedge CLK); #1;
      checkIdle($sformatf("v%0d idle", n));
   endtask

   task automatic doReset(input int cycles);
      @(negedge CLK);
      CLR = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(posedge CLK); #1;
         checkIdle($sformatf("reset c%0d", c));
      end
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   task automatic waitFor(input string name, input bit want_done, output bit ok);
      int cyc;
      cyc = 0;
      while ((want_done ? (done == 4'b0000) : (gnt == 4'b0000)) && cyc < 20) begin
         @(posedge CLK); #1;
         cyc++;
      end
      ok = want_done ? (done != 4'b0000) : (gnt != 4'b0000);
      if (!ok) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s: timeout after %0d cycles, got gnt=%b done=%b", name, cyc, gnt, done);
      end
   endtask

   initial begin
      bit         ok;
      logic [3:0] eg;
      int         fair_rr [5] = '{0, 1, 2, 3, 0};

      vecs[0] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 0, 0, 5'b00001, 1'b0, 1'b1};
      vecs[1] = '{4'b0100, 8'b00_10_00_00, 4'b0010, 2, 2, 5'b00100, 1'b1, 1'b1};
      vecs[2] = '{4'b0010, 8'b00_00_11_00, 4'b1111, 1, 1, 5'b10000, 1'b0, 1'b0};
      vecs[3] = '{4'b1000, 8'b01_00_00_00, 4'b1000, 3, 3, 5'b00001, 1'b0, 1'b1};
      vecs[4] = '{4'b1111, 8'b01_10_00_00, 4'b0000, 2, 2, 5'b00100, 1'b0, 1'b1};
      vecs[5] = '{4'b1011, 8'b01_01_01_01, 4'b0000, 3, 0, 5'b00001, 1'b0, 1'b1};
      vecs[6] = '{4'b1011, 8'b01_01_01_01, 4'b0000, 0, 0, 5'b00001, 1'b0, 1'b1};
      vecs[7] = '{4'b1011, 8'b01_01_01_01, 4'b0000, 1, 0, 5'b00001, 1'b0, 1'b1};
      vecs[8] = '{4'b0001, 8'b00_00_00_01, 4'b0100, 0, 0, 5'b00001, 1'b1, 1'b1};

      CLR         = 1'b1;
      req         = 4'b1111;
      req_cmd     = 8'b11_10_01_11;
      snoop_abort = 4'b1111;
      doReset(2);
      req         = 4'b0000;
      req_cmd     = 8'h00;
      snoop_abort = 4'b0000;
      @(posedge CLK); #1;
      checkIdle("post-reset idle");

      for (int i = 0; i < 9; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Continuous request from every cache shows the grant rotation.
      doReset(1);
      @(negedge CLK);
      req     = 4'b1111;
      req_cmd = 8'b01_01_01_01;
      for (int t = 0; t < 5; t++) begin
`ifdef MESI_ARB_FIXED_PRIO_EN
         eg = 4'b0001;
`else
         eg = 4'b0001 << fair_rr[t];
`endif
         waitFor($sformatf("fair%0d gnt", t), 1'b0, ok);
         if (ok) compare($sformatf("fair%0d gnt", t), {13'd0, gnt}, {13'd0, eg});
         waitFor($sformatf("fair%0d done", t), 1'b1, ok);
         if (ok) compare($sformatf("fair%0d done", t), {13'd0, done}, {13'd0, eg});
         if (t == 4) req = 4'b0000;
         @(posedge CLK); #1;
      end
      req_cmd = 8'h00;
      @(posedge CLK); #1;
      checkIdle("fair idle");

      // Reset while a write-back is in flight abandons it and restores cache-0 priority.
      @(negedge CLK);
      req         = 4'b0010;
      req_cmd     = 8'b00_00_10_00;
      snoop_abort = 4'b0001;
      @(posedge CLK); #1;
      checkOutput("rwb bcast", 4'b0010, 5'b00100, 2'd1, 1'b0, 1'b0, 4'b0000);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      checkOutput("rwb wb", 4'b0010, 5'b00000, 2'd1, 1'b1, 1'b0, 4'b0000);
      @(negedge CLK);
      CLR         = 1'b1;
      req         = 4'b0000;
      req_cmd     = 8'h00;
      snoop_abort = 4'b0000;
      @(posedge CLK); #1;
      checkIdle("rwb after reset");
      @(negedge CLK);
      CLR = 1'b0;
      @(posedge CLK); #1;
      checkIdle("rwb no done");
      @(negedge CLK);
      req     = 4'b0011;
      req_cmd = 8'b00_00_01_01;
      @(posedge CLK); #1;
      checkOutput("rwb next bcast", 4'b0001, 5'b00001, 2'd0, 1'b0, 1'b0, 4'b0000);
      waitFor("rwb next done", 1'b1, ok);
      if (ok) compare("rwb next done", {13'd0, done}, 17'd1);
      req     = 4'b0000;
      req_cmd = 8'h00;
      @(posedge CLK); #1;
      checkIdle("rwb final idle");

      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

endmodule
